// File: rtl/aq_hpcp_ovf_int_ctrl.sv
// HPCP counter-overflow interrupt controller.
// Keeps a sticky overflow status vector and a saturating count of lost overflows.
// Raises a level interrupt request, handshaken with vld/ack, whenever an enabled
// status bit is set. Also serves CSR read-back with a fixed one-cycle latency.
module aq_hpcp_ovf_int_ctrl #(
    parameter int NUM_CNT = 32,
    parameter int LOST_W  = 8
) (
    input  logic               hpcp_clk,
    input  logic               cpurst,
    input  logic [NUM_CNT-1:0] cntinten,
    input  logic [NUM_CNT-1:0] cnt_ovf_pulse,
    input  logic               ovf_clr_wen,
    input  logic [NUM_CNT-1:0] hpcp_wdata,
    input  logic               hpcp_rd_req,
    input  logic [1:0]         hpcp_rd_sel,
    output logic               hpcp_rd_vld,
    output logic [31:0]        hpcp_rd_data,
    output logic               hpcp_int_vld,
    input  logic               hpcp_int_ack,
    output logic [NUM_CNT-1:0] ovf_status
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } state_t;

    state_t             state;
    logic [LOST_W-1:0]  lost_cnt;
    logic [NUM_CNT-1:0] clr_mask;
    logic               lost_hit;
    logic               lost_clr;
    logic               pending;
    logic [31:0]        rd_mux;

    // Clear mask, lost-overflow detect and interrupt pending.
    // Set wins over clear, so a pulse on an already-set bit is always lost,
    // even when that bit is being cleared in the same cycle.
    always_comb begin
        clr_mask = ovf_clr_wen ? hpcp_wdata : '0;
        lost_hit = |(cnt_ovf_pulse & ovf_status);
        lost_clr = ovf_clr_wen && (hpcp_wdata == {NUM_CNT{1'b1}});
        pending  = |(ovf_status & cntinten);
    end

    // Sticky status: set by overflow pulses, cleared by write-1-to-clear.
    always_ff @(posedge hpcp_clk) begin
        if (cpurst) begin
            ovf_status <= '0;
        end else begin
            ovf_status <= cnt_ovf_pulse | (ovf_status & ~clr_mask);
        end
    end

    // Saturating lost-overflow counter; a full-mask clear takes priority over an increment.
    always_ff @(posedge hpcp_clk) begin
        if (cpurst) begin
            lost_cnt <= '0;
        end else if (lost_clr) begin
            lost_cnt <= '0;
        end else if (lost_hit && (lost_cnt != {LOST_W{1'b1}})) begin
            lost_cnt <= lost_cnt + 1'b1;
        end
    end

    // Interrupt handshake FSM; the request is retracted if pending drops before ack.
    always_ff @(posedge hpcp_clk) begin
        if (cpurst) begin
            state        <= IDLE;
            hpcp_int_vld <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pending) begin
                        state        <= REQ;
                        hpcp_int_vld <= 1'b1;
                    end
                end
                REQ: begin
                    if (hpcp_int_ack) begin
                        state        <= SVC;
                        hpcp_int_vld <= 1'b0;
                    end else if (!pending) begin
                        state        <= IDLE;
                        hpcp_int_vld <= 1'b0;
                    end
                end
                SVC: begin
                    if (!pending) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    hpcp_int_vld <= 1'b0;
                end
            endcase
        end
    end

    // CSR read source select, zero-extended to 32 bits.
    always_comb begin
        rd_mux = '0;
        case (hpcp_rd_sel)
            2'd0:    rd_mux = 32'(ovf_status);
            2'd1:    rd_mux = 32'(cntinten);
            2'd2:    rd_mux = 32'(lost_cnt);
            default: rd_mux = '0;
        endcase
    end

    // Read response registered one cycle after the request; data is zero when idle.
    always_ff @(posedge hpcp_clk) begin
        if (cpurst) begin
            hpcp_rd_vld  <= 1'b0;
            hpcp_rd_data <= '0;
        end else begin
            hpcp_rd_vld  <= hpcp_rd_req;
            hpcp_rd_data <= hpcp_rd_req ? rd_mux : '0;
        end
    end

endmodule
